elevator_car_drive: RTL

Car/shaft responder for the 4-floor elevator controller. It consumes the controller's `move_up`, `move_down` and `door_open` commands and models the car:
- timed floor-to-floor travel;
- a door open/close mechanism with interlock;
- registered position, arrival and door status back to the controller and LEDs.

It sits on the opposite end of the command interface from the elevator FSM and replaces the FSM's implicit "one floor per cycle" assumption with real travel time.

---
 rtl/elevator_car_drive.sv | 284 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/elevator_car_drive.sv
// -----------------------------------------------------------------------------
// elevator_car_drive
//
// Car and shaft responder for the 4-floor elevator controller. It takes the
// controller's move_up / move_down / door_open commands and models:
//   - timed floor-to-floor travel,
//   - a door open/close mechanism with movement interlock,
//   - registered position, arrival and door status.
//
// Ports
//   clk          in   clock
//   rst_n        in   asynchronous active-low reset
//   move_up      in   command: travel up
//   move_down    in   command: travel down
//   door_open    in   command: open / hold door open
//   floor_pos    out  current or last-passed floor
//   arrive       out  one-cycle pulse when the car reaches a floor
//   moving_up    out  car travelling up
//   moving_down  out  car travelling down
//   door_state   out  00 closed, 01 opening, 10 open, 11 closing
//   fault        out  sticky fault flag
//   fault_code   out  00 none, 01 up+down, 10 overtravel, 11 move with door_open
//
// Build option
//   ELEVATOR_CAR_FAULT_EN  defined: fault detection and a sticky FAULT state.
//                          undefined: fault/fault_code tied 0; illegal
//                          command combinations are resolved without faulting.
// -----------------------------------------------------------------------------
module elevator_car_drive #(
  parameter int NUM_FLOORS    = 4,
  parameter int FLOOR_W       = 2,
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               move_up,
  input  logic               move_down,
  input  logic               door_open,
  output logic [FLOOR_W-1:0] floor_pos,
  output logic               arrive,
  output logic               moving_up,
  output logic               moving_down,
  output logic [1:0]         door_state,
  output logic               fault,
  output logic [1:0]         fault_code
);

  localparam int TCNT_W = $clog2(TRAVEL_CYCLES);
  localparam int DCNT_W = $clog2(DOOR_CYCLES);

  localparam logic [FLOOR_W-1:0] TOP    = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [FLOOR_W-1:0] TOP_M1 = FLOOR_W'(NUM_FLOORS - 2);
  localparam logic [FLOOR_W-1:0] BOT_P1 = FLOOR_W'(1);
  localparam logic [TCNT_W-1:0]  T_LAST = TCNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [DCNT_W-1:0]  D_LAST = DCNT_W'(DOOR_CYCLES - 1);

  localparam logic [1:0] DS_CLOSED  = 2'b00;
  localparam logic [1:0] DS_OPENING = 2'b01;
  localparam logic [1:0] DS_OPEN    = 2'b10;
  localparam logic [1:0] DS_CLOSING = 2'b11;

  typedef enum logic [2:0] {
    PARKED       = 3'd0,
    TRAVEL_UP    = 3'd1,
    TRAVEL_DOWN  = 3'd2,
    DOOR_OPENING = 3'd3,
    DOOR_OPEN    = 3'd4,
    DOOR_CLOSING = 3'd5
`ifdef ELEVATOR_CAR_FAULT_EN
    ,FAULT       = 3'd6
`endif
  } state_e;

  state_e              state_q, state_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
  logic [FLOOR_W-1:0]  floor_q, floor_d;
  logic                arrive_q, arrive_d;
  logic                mup_q, mup_d;
  logic                mdn_q, mdn_d;
  logic [1:0]          door_q, door_d;

  logic at_top, at_bot, t_done, d_done;

  assign at_top = (floor_q == TOP);
  assign at_bot = (floor_q == '0);
  assign t_done = (tcnt_q == T_LAST);
  assign d_done = (dcnt_q == D_LAST);

`ifdef ELEVATOR_CAR_FAULT_EN
  logic       fault_q, fault_d;
  logic [1:0] fcode_q, fcode_d;
  logic       ovt, flt_hit;
  logic [1:0] flt_code;

  // Overtravel only exists where the car is about to leave a floor: while
  // parked, or at the arrival edge where continuation would be decided.
  always_comb begin
    ovt      = 1'b0;
    flt_hit  = 1'b0;
    flt_code = 2'b00;
    if (state_q == PARKED)
      ovt = (move_up && at_top) || (move_down && at_bot);
    else if (state_q == TRAVEL_UP && t_done)
      ovt = move_up && (floor_q == TOP_M1);
    else if (state_q == TRAVEL_DOWN && t_done)
      ovt = move_down && (floor_q == BOT_P1);

    if (state_q != FAULT) begin
      if (move_up && move_down) begin
        flt_hit  = 1'b1;
        flt_code = 2'b01;
      end else if ((move_up || move_down) && door_open) begin
        flt_hit  = 1'b1;
        flt_code = 2'b11;
      end else if (ovt) begin
        flt_hit  = 1'b1;
        flt_code = 2'b10;
      end
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    dcnt_d   = dcnt_q;
    floor_d  = floor_q;
    arrive_d = 1'b0;
    mup_d    = mup_q;
    mdn_d    = mdn_q;
    door_d   = door_q;
`ifdef ELEVATOR_CAR_FAULT_EN
    fault_d  = fault_q;
    fcode_d  = fcode_q;
`endif

    case (state_q)
      PARKED: begin
        // door_open outranks movement, which also resolves move+door in
        // favour of the door when faults are not built in.
        if (door_open) begin
          state_d = DOOR_OPENING;
          door_d  = DS_OPENING;
          dcnt_d  = '0;
        end else if (move_up && !move_down && !at_top) begin
          state_d = TRAVEL_UP;
          mup_d   = 1'b1;
          tcnt_d  = '0;
        end else if (move_down && !move_up && !at_bot) begin
          state_d = TRAVEL_DOWN;
          mdn_d   = 1'b1;
          tcnt_d  = '0;
        end
      end

      TRAVEL_UP: begin
        if (!t_done) begin
          tcnt_d = tcnt_q + 1'b1;
        end else begin
          floor_d  = floor_q + 1'b1;
          arrive_d = 1'b1;
          tcnt_d   = '0;
          // Continue without a gap only if another floor lies above.
          if (!(move_up && !move_down && floor_q != TOP_M1)) begin
            state_d = PARKED;
            mup_d   = 1'b0;
          end
        end
      end

      TRAVEL_DOWN: begin
        if (!t_done) begin
          tcnt_d = tcnt_q + 1'b1;
        end else begin
          floor_d  = floor_q - 1'b1;
          arrive_d = 1'b1;
          tcnt_d   = '0;
          if (!(move_down && !move_up && floor_q != BOT_P1)) begin
            state_d = PARKED;
            mdn_d   = 1'b0;
          end
        end
      end

      DOOR_OPENING: begin
        if (d_done) begin
          state_d = DOOR_OPEN;
          door_d  = DS_OPEN;
          dcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end

      DOOR_OPEN: begin
        if (!door_open) begin
          state_d = DOOR_CLOSING;
          door_d  = DS_CLOSING;
          dcnt_d  = '0;
        end
      end

      DOOR_CLOSING: begin
        // Safety reopen wins over completing the close.
        if (door_open) begin
          state_d = DOOR_OPENING;
          door_d  = DS_OPENING;
          dcnt_d  = '0;
        end else if (d_done) begin
          state_d = PARKED;
          door_d  = DS_CLOSED;
          dcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end

`ifdef ELEVATOR_CAR_FAULT_EN
      FAULT: ;
`endif

      default: state_d = PARKED;
    endcase

`ifdef ELEVATOR_CAR_FAULT_EN
    // A fault freezes motion and door; an arrival on the same edge still
    // records the floor the car actually reached.
    if (flt_hit) begin
      state_d = FAULT;
      fault_d = 1'b1;
      fcode_d = flt_code;
      mup_d   = 1'b0;
      mdn_d   = 1'b0;
      door_d  = door_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= PARKED;
      tcnt_q   <= '0;
      dcnt_q   <= '0;
      floor_q  <= '0;
      arrive_q <= 1'b0;
      mup_q    <= 1'b0;
      mdn_q    <= 1'b0;
      door_q   <= DS_CLOSED;
`ifdef ELEVATOR_CAR_FAULT_EN
      fault_q  <= 1'b0;
      fcode_q  <= 2'b00;
`endif
    end else begin
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      dcnt_q   <= dcnt_d;
      floor_q  <= floor_d;
      arrive_q <= arrive_d;
      mup_q    <= mup_d;
      mdn_q    <= mdn_d;
      door_q   <= door_d;
`ifdef ELEVATOR_CAR_FAULT_EN
      fault_q  <= fault_d;
      fcode_q  <= fcode_d;
`endif
    end
  end

  assign floor_pos   = floor_q;
  assign arrive      = arrive_q;
  assign moving_up   = mup_q;
  assign moving_down = mdn_q;
  assign door_state  = door_q;
`ifdef ELEVATOR_CAR_FAULT_EN
  assign fault       = fault_q;
  assign fault_code  = fcode_q;
`else
  assign fault       = 1'b0;
  assign fault_code  = 2'b00;
`endif

endmodule
